// File: rtl/step_sequencer_pkg.sv
// Shared types and defaults for the step sequencer and its tick timer.
// Also used by the bench, so state encodings live in one place.
package step_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    REPEAT = 2'd2,
    CLEAR  = 2'd3
  } seq_state_t;

  localparam int DEF_HOLD_TICKS = 50;
  localparam int DEF_RPT_TICKS  = 10;

  // Timer must be able to represent the larger of the two limits.
  function automatic int timer_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/step_sequencer_tick_timer.sv
// Saturating tick-strobe counter; done holds while the count has reached limit.
module tick_timer #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         tick,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        cnt <= '0;
    else if (clr)                     cnt <= '0;
    else if (tick && (cnt != '1))     cnt <= cnt + 1'b1;
  end

  assign done = (cnt >= limit);

endmodule

// File: rtl/step_sequencer.sv
// Step-switch sequencer: single step on press, auto-repeat while held,
// clear request override and optional saturation at the counter limits.
module step_sequencer
  import step_sequencer_pkg::*;
#(
  parameter int HOLD_TICKS = DEF_HOLD_TICKS,
  parameter int RPT_TICKS  = DEF_RPT_TICKS,
  parameter bit SAT        = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        ped,
  input  logic        held,
  input  logic        clr,
  input  logic        uhdl,
  input  logic [31:0] count,
  output logic        step,
  output logic        up,
  output logic        clear,
  output logic        busy,
  output logic [1:0]  state
);

  localparam int TW = timer_width(HOLD_TICKS, RPT_TICKS);
  localparam logic [TW-1:0] HOLD_L = TW'(HOLD_TICKS);
  localparam logic [TW-1:0] RPT_L  = TW'(RPT_TICKS);

  seq_state_t    st;
  logic          counting, tmr_tick, tmr_clr, done;
  logic [TW-1:0] limit;

  // Timer only runs in ARM/REPEAT with the switch held; it restarts on every
  // expiry and sits at zero elsewhere, so entering ARM always starts fresh.
  always_comb begin
    counting = (st == ARM) || (st == REPEAT);
    limit    = (st == ARM) ? HOLD_L : RPT_L;
    tmr_tick = tick && counting && held;
    tmr_clr  = !counting || done;
  end

  tick_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr),
    .tick  (tmr_tick),
    .limit (limit),
    .done  (done)
  );

  function automatic logic blocked(input logic dir);
    return SAT && (dir ? (count == 32'hFFFF_FFFF) : (count == 32'd0));
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st    <= IDLE;
      step  <= 1'b0;
      up    <= 1'b0;
      clear <= 1'b0;
      busy  <= 1'b0;
    end else begin
      step  <= 1'b0;
      clear <= 1'b0;
      busy  <= 1'b0;
      if (clr) begin
        st    <= CLEAR;
        clear <= 1'b1;
      end else begin
        case (st)
          IDLE: if (ped) begin
            st   <= ARM;
            up   <= uhdl;
            step <= !blocked(uhdl);
          end
          ARM: begin
            if (!held) st <= IDLE;
            else if (done) begin
              st   <= REPEAT;
              busy <= 1'b1;
              up   <= uhdl;
              step <= !blocked(uhdl);
            end
          end
          REPEAT: begin
            if (!held) st <= IDLE;
            else begin
              busy <= 1'b1;
              if (done) begin
                up   <= uhdl;
                step <= !blocked(uhdl);
              end
            end
          end
          CLEAR:   st <= IDLE;
          default: st <= IDLE;
        endcase
      end
    end
  end

  assign state = st;

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer: cycle table plus hand-written sequences.
module tb_step_sequencer;
  import step_sequencer_pkg::*;

  localparam int H = 4;
  localparam int R = 2;

  logic clk = 1'b0;
  logic reset, tick, ped, held, clr, uhdl;
  logic [31:0] count;
  logic step0, up0, clear0, busy0, step1, up1, clear1, busy1;
  logic [1:0] st0, st1;

  int n_cmp = 0, n_bad = 0, tick_n = 0, viol = 0;
  int   step_tk[$];
  logic step_up[$];
  logic pstep0 = 1'b0, pstep1 = 1'b0;

  step_sequencer #(.HOLD_TICKS(H), .RPT_TICKS(R), .SAT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .ped(ped), .held(held), .clr(clr),
    .uhdl(uhdl), .count(count), .step(step0), .up(up0), .clear(clear0),
    .busy(busy0), .state(st0));

  step_sequencer #(.HOLD_TICKS(H), .RPT_TICKS(R), .SAT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .ped(ped), .held(held), .clr(clr),
    .uhdl(uhdl), .count(count), .step(step1), .up(up1), .clear(clear1),
    .busy(busy1), .state(st1));

  always #5 clk = ~clk;

  // Record every dut0 step with the tick index it followed; flag illegal pulse shapes.
  always @(negedge clk) begin
    if (step0 === 1'b1) begin
      step_tk.push_back(tick_n);
      step_up.push_back(up0);
    end
    if ((step0 === 1'b1 && clear0 === 1'b1) || (step1 === 1'b1 && clear1 === 1'b1) ||
        (step0 === 1'b1 && pstep0 === 1'b1) || (step1 === 1'b1 && pstep1 === 1'b1))
      viol++;
    pstep0 = step0;
    pstep1 = step1;
  end

  typedef struct {
    logic ped, held, clr, uhdl, tick;
    logic step, up, clear, busy;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[23];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; tick = 1'b0; ped = 1'b0; held = 1'b0; clr = 1'b0; uhdl = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_tick();
    @(negedge clk); tick = 1'b1; tick_n++;
    @(negedge clk); tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic pulse_ped();
    @(negedge clk); ped = 1'b1;
    @(negedge clk); ped = 1'b0;
  endtask

  initial begin
    count = 32'd5;
    reset = 1'b1; tick = 1'b0; ped = 1'b0; held = 1'b0; clr = 1'b0; uhdl = 1'b0;
    #12;
    check("reset_outputs", {27'd0, step0, up0, clear0, busy0, 1'b0}, 32'd0);
    check("reset_state", {30'd0, st0}, {30'd0, IDLE});

    //          ped held clr uhdl tick | step up clear busy state
    tbl[0]  = '{0, 0, 0, 0, 0,  0, 0, 0, 0, IDLE};
    tbl[1]  = '{1, 1, 0, 1, 0,  1, 1, 0, 0, ARM};
    tbl[2]  = '{0, 1, 0, 1, 0,  0, 1, 0, 0, ARM};
    tbl[3]  = '{0, 1, 0, 1, 1,  0, 1, 0, 0, ARM};
    tbl[4]  = '{0, 1, 0, 1, 0,  0, 1, 0, 0, ARM};
    tbl[5]  = '{0, 0, 0, 1, 0,  0, 1, 0, 0, IDLE};
    tbl[6]  = '{1, 1, 0, 0, 0,  1, 0, 0, 0, ARM};
    tbl[7]  = '{0, 1, 0, 0, 1,  0, 0, 0, 0, ARM};
    tbl[8]  = '{0, 1, 0, 0, 1,  0, 0, 0, 0, ARM};
    tbl[9]  = '{0, 1, 0, 0, 1,  0, 0, 0, 0, ARM};
    tbl[10] = '{0, 1, 0, 0, 1,  0, 0, 0, 0, ARM};
    tbl[11] = '{0, 1, 0, 0, 0,  1, 0, 0, 1, REPEAT};
    tbl[12] = '{0, 1, 0, 0, 1,  0, 0, 0, 1, REPEAT};
    tbl[13] = '{0, 1, 0, 1, 1,  0, 0, 0, 1, REPEAT};
    tbl[14] = '{0, 1, 0, 1, 0,  1, 1, 0, 1, REPEAT};
    tbl[15] = '{1, 1, 0, 1, 0,  0, 1, 0, 1, REPEAT};
    tbl[16] = '{0, 1, 1, 1, 0,  0, 1, 1, 0, CLEAR};
    tbl[17] = '{0, 1, 0, 1, 0,  0, 1, 0, 0, IDLE};
    tbl[18] = '{0, 1, 0, 1, 1,  0, 1, 0, 0, IDLE};
    tbl[19] = '{1, 1, 1, 1, 0,  0, 1, 1, 0, CLEAR};
    tbl[20] = '{0, 1, 0, 1, 0,  0, 1, 0, 0, IDLE};
    tbl[21] = '{1, 0, 0, 0, 0,  1, 0, 0, 0, ARM};
    tbl[22] = '{0, 0, 0, 0, 0,  0, 0, 0, 0, IDLE};

    do_reset();
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      ped = tbl[i].ped; held = tbl[i].held; clr = tbl[i].clr;
      uhdl = tbl[i].uhdl; tick = tbl[i].tick;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), {26'd0, step0, up0, clear0, busy0, st0},
            {26'd0, tbl[i].step, tbl[i].up, tbl[i].clear, tbl[i].busy, tbl[i].st});
    end

    // Short hold: one step only, direction from uhdl, back to IDLE.
    do_reset();
    step_tk.delete(); step_up.delete(); tick_n = 0;
    held = 1'b1; uhdl = 1'b1;
    pulse_ped();
    do_tick();
    held = 1'b0;
    repeat (3) @(negedge clk);
    check("short_nsteps", step_tk.size(), 1);
    check("short_up", (step_up.size() > 0) ? {31'd0, step_up[0]} : 32'hDEAD, 32'd1);
    check("short_state", {30'd0, st0}, {30'd0, IDLE});

    // Long hold: steps at ticks 0, 4, 6, 8, 10; busy from tick 4.
    do_reset();
    step_tk.delete(); step_up.delete(); tick_n = 0;
    held = 1'b1; uhdl = 1'b1;
    pulse_ped();
    for (int k = 1; k <= 10; k++) begin
      do_tick();
      check($sformatf("long_busy_t%0d", k), {31'd0, busy0}, (k >= H) ? 32'd1 : 32'd0);
    end
    held = 1'b0;
    repeat (2) @(negedge clk);
    check("long_nsteps", step_tk.size(), 5);
    begin
      int exp_tk[5] = '{0, 4, 6, 8, 10};
      for (int i = 0; i < 5; i++)
        check($sformatf("long_step%0d_tick", i),
              (i < step_tk.size()) ? step_tk[i] : -1, exp_tk[i]);
    end
    check("long_idle", {30'd0, st0}, {30'd0, IDLE});

    // clr and ped together: clear wins, no auto-restart while held.
    do_reset();
    step_tk.delete(); step_up.delete();
    held = 1'b1;
    @(negedge clk); ped = 1'b1; clr = 1'b1;
    @(negedge clk); ped = 1'b0; clr = 1'b0;
    check("clrped_clear", {31'd0, clear0}, 32'd1);
    check("clrped_step", {31'd0, step0}, 32'd0);
    check("clrped_state", {30'd0, st0}, {30'd0, CLEAR});
    @(negedge clk);
    check("clrped_clear_1cyc", {31'd0, clear0}, 32'd0);
    check("clrped_idle", {30'd0, st0}, {30'd0, IDLE});
    for (int k = 0; k < 20; k++) do_tick();
    check("clrped_nsteps", step_tk.size(), 0);
    check("clrped_still_idle", {30'd0, st0}, {30'd0, IDLE});

    // Saturation on dut1; dut0 (wrapping) steps regardless.
    do_reset();
    held = 1'b0; count = 32'hFFFF_FFFF; uhdl = 1'b1;
    pulse_ped();
    check("sat_top_up_blocked", {31'd0, step1}, 32'd0);
    check("sat_top_up_latched", {31'd0, up1}, 32'd1);
    check("wrap_top_steps", {31'd0, step0}, 32'd1);
    repeat (2) @(negedge clk);
    uhdl = 1'b0;
    pulse_ped();
    check("sat_top_down_step", {31'd0, step1}, 32'd1);
    check("sat_top_down_up", {31'd0, up1}, 32'd0);
    repeat (2) @(negedge clk);
    count = 32'd0;
    pulse_ped();
    check("sat_zero_down_blocked", {31'd0, step1}, 32'd0);
    repeat (2) @(negedge clk);
    uhdl = 1'b1;
    pulse_ped();
    check("sat_zero_up_step", {31'd0, step1}, 32'd1);
    repeat (2) @(negedge clk);
    count = 32'd5;

    // Asynchronous reset during REPEAT.
    do_reset();
    step_tk.delete(); step_up.delete(); tick_n = 0;
    held = 1'b1; uhdl = 1'b1;
    pulse_ped();
    for (int k = 0; k < 5; k++) do_tick();
    check("rst_pre_busy", {31'd0, busy0}, 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check("rst_async_outputs", {27'd0, step0, up0, clear0, busy0, 1'b0}, 32'd0);
    check("rst_async_state", {30'd0, st0}, {30'd0, IDLE});
    @(negedge clk); reset = 1'b0;
    step_tk.delete(); step_up.delete();
    for (int k = 0; k < 20; k++) do_tick();
    check("rst_no_steps", step_tk.size(), 0);
    pulse_ped();
    check("rst_new_ped_step", {31'd0, step0}, 32'd1);
    held = 1'b0;
    repeat (3) @(negedge clk);

    check("pulse_rules", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/step_sequencer.md
STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 Parameter HOLD_TICKS, default 50: ticks a held switch must stay high after the first step before auto-repeat starts.
REQ-002 Parameter RPT_TICKS, default 10: ticks between auto-repeat steps.
REQ-003 Parameter SAT, default 0: 1 means saturate at count limits, 0 means counter wraps freely.
REQ-004 clk  in  1  single system clock; all logic rising-edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 tick  in  1  one-cycle time-base strobe from the debounce ticker.
REQ-007 ped  in  1  one-cycle rising-edge pulse of the debounced step switch.
REQ-008 held  in  1  debounced level of the same step switch.
REQ-009 clr  in  1  one-cycle clear-request pulse.
REQ-010 uhdl  in  1  direction select: 1 means up, 0 means down.
REQ-011 count  in  32  current counter value, used for saturation only.
REQ-012 step  out  1  one-cycle step command to the counter.
REQ-013 up  out  1  direction qualifying step, valid while step=1.
REQ-014 clear  out  1  one-cycle synchronous clear command to the counter.
REQ-015 busy  out  1  high while in REPEAT.
REQ-016 state  out  2  current FSM state: IDLE=0, ARM=1, REPEAT=2, CLEAR=3.

Function
REQ-017 FSM states SHALL be IDLE, ARM, REPEAT and CLEAR; all outputs are registered.
REQ-018 IDLE: on ped=1, the block SHALL assert step on the next cycle, latch up from uhdl, clear the tick timer and enter ARM.
REQ-019 ARM: the timer SHALL count tick strobes while held=1; held=0 returns to IDLE with no step.
REQ-020 ARM: when the timer reaches HOLD_TICKS, the block SHALL enter REPEAT, emit one step and clear the timer.
REQ-021 REPEAT: each time the timer reaches RPT_TICKS, the block SHALL emit one step and clear the timer; held=0 returns to IDLE.
REQ-022 uhdl SHALL be resampled at every step emission, so a direction change takes effect on the next step.
REQ-023 clr=1 in any state SHALL go to CLEAR: clear=1 for exactly one cycle, no step, then IDLE even if held=1; a new ped is required to step again.
REQ-024 clr and ped in the same cycle: clr SHALL win and the ped is discarded.
REQ-025 ped while in ARM, REPEAT or CLEAR SHALL be ignored.
REQ-026 step and clear SHALL never be high in the same cycle; step SHALL never be high on consecutive cycles.
REQ-027 SAT=1: the step pulse SHALL be suppressed when up=1 and count=32'hFFFFFFFF, or up=0 and count=0; FSM and timer advance unchanged.
REQ-028 SAT=0: the step pulse SHALL be emitted regardless of count.
REQ-029 The tick timer SHALL be wide enough for max(HOLD_TICKS, RPT_TICKS), saturate rather than wrap, and ignore tick during CLEAR.

Reset
REQ-030 On reset=1: state=IDLE, timer=0, step=0, up=0, clear=0, busy=0, applied asynchronously.
REQ-031 Reset asserted mid-ARM or mid-REPEAT SHALL abort with no further step; after release the block waits in IDLE for a fresh ped.

Structure
REQ-032 State encodings and default HOLD_TICKS/RPT_TICKS values SHALL live in a shared package used by the block and the bench.
REQ-033 The tick timer SHALL be a sub-module tick_timer (inputs: clk, reset, clr, tick, limit; output: done).

Verification
REQ-034 HOLD_TICKS=4, RPT_TICKS=2; ped with held pulsed for 1 tick -> exactly one step, up=uhdl, FSM returns to IDLE.
REQ-035 Same parameters, held high for 10 ticks -> step at ped, at tick 4, then at ticks 6, 8 and 10; busy=1 from tick 4.
REQ-036 clr and ped in the same cycle -> clear=1 for 1 cycle, step=0, state IDLE, still IDLE after 20 ticks with held=1.
REQ-037 SAT=1, count=32'hFFFFFFFF, uhdl=1, ped -> no step; uhdl=0 then ped -> step with up=0.
REQ-038 Reset pulse during REPEAT -> all outputs 0 immediately, no step for 20 ticks with held=1 until a new ped.
REQ-039 uhdl toggled during REPEAT -> the next step carries the new up value, earlier steps unchanged.
